sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 113 +++++++++++
 tb/tb_sum_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums FRAME_LEN unsigned samples into a wrapping ACC_WD-bit total.
// The total is held with a sticky overflow flag until downstream takes it.
module sum_accumulator #(
  parameter int DATA_WD   = 16,
  parameter int FRAME_LEN = 4,
  parameter int ACC_WD    = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic [DATA_WD:0]   i_sum,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [ACC_WD-1:0]  o_total,
  output logic               o_ovf,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [8:0]         o_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [8:0] LAST_COUNT = 9'(FRAME_LEN - 1);

  state_t              state_reg, state_next;
  logic [ACC_WD-1:0]   acc_reg, acc_next;
  logic [ACC_WD-1:0]   total_reg, total_next;
  logic                ovf_reg, ovf_next;
  logic                res_ovf_reg, res_ovf_next;
  logic [8:0]          count_reg, count_next;
  logic                accept;
  logic                last;
  logic [ACC_WD:0]     sum_wide;

  // Ready is a pure state decode so nothing combinational loops back from the handshakes.
  assign o_ready  = (state_reg != HOLD);
  assign o_valid  = (state_reg == HOLD);
  assign o_total  = total_reg;
  assign o_ovf    = res_ovf_reg;
  assign o_count  = count_reg;

  assign accept   = i_valid && (state_reg != HOLD);
  assign last     = (count_reg == LAST_COUNT);
  assign sum_wide = {1'b0, acc_reg} + {1'b0, ACC_WD'(i_sum)};

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    total_next   = total_reg;
    ovf_next     = ovf_reg;
    res_ovf_next = res_ovf_reg;
    count_next   = count_reg;

    if (i_clear) begin
      state_next = IDLE;
      acc_next   = '0;
      ovf_next   = 1'b0;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_next   = ACC_WD'(i_sum);
            ovf_next   = 1'b0;
            count_next = 9'd1;
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last) begin
              total_next   = sum_wide[ACC_WD-1:0];
              res_ovf_next = ovf_reg | sum_wide[ACC_WD];
              acc_next     = '0;
              ovf_next     = 1'b0;
              count_next   = '0;
              state_next   = HOLD;
            end else begin
              acc_next   = sum_wide[ACC_WD-1:0];
              ovf_next   = ovf_reg | sum_wide[ACC_WD];
              count_next = count_reg + 9'd1;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      total_reg   <= '0;
      ovf_reg     <= 1'b0;
      res_ovf_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      total_reg   <= total_next;
      ovf_reg     <= ovf_next;
      res_ovf_reg <= res_ovf_next;
      count_reg   <= count_next;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed and randomized checks of sum_accumulator; a second instance with
// ACC_WD = 17 shares all inputs so overflow behaviour is observed side by side.
module tb_sum_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clear;
  logic [16:0] i_sum;
  logic        i_valid;
  logic        i_ready;

  logic        o_ready, o_ovf, o_valid;
  logic [23:0] o_total;
  logic [8:0]  o_count;

  logic        o_ready17, o_ovf17, o_valid17;
  logic [16:0] o_total17;
  logic [8:0]  o_count17;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  sum_accumulator dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_sum(i_sum),
    .i_valid(i_valid), .o_ready(o_ready), .o_total(o_total), .o_ovf(o_ovf),
    .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count)
  );

  sum_accumulator #(.DATA_WD(16), .FRAME_LEN(4), .ACC_WD(17)) dut17 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_sum(i_sum),
    .i_valid(i_valid), .o_ready(o_ready17), .o_total(o_total17), .o_ovf(o_ovf17),
    .o_valid(o_valid17), .i_ready(i_ready), .o_count(o_count17)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [16:0] v);
    i_valid = 1'b1;
    i_sum   = v;
    tick();
  endtask

  // Reference model state: samples of the open frame and the pending result.
  logic [16:0]     q[$];
  bit              hold;
  longint unsigned s;
  logic [31:0]     exp_total, exp_total17;
  logic            exp_ovf, exp_ovf17;
  int              frames;

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_sum = '0; i_valid = 1'b0; i_ready = 1'b0;
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_total", 32'(o_total), 32'd0);
    check("rst_ovf",   32'(o_ovf),   32'd0);
    tick();
    i_rst = 1'b0;

    // Basic frame 1,2,3,4 with downstream always ready
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(17'(i + 1));
      if (i < 3) check("seq_count", 32'(o_count), 32'(i + 1));
    end
    i_valid = 1'b0;
    check("seq_valid", 32'(o_valid), 32'd1);
    check("seq_total", 32'(o_total), 32'd10);
    check("seq_ovf",   32'(o_ovf),   32'd0);
    check("seq_ready_hold", 32'(o_ready), 32'd0);
    check("seq_count_end",  32'(o_count), 32'd0);
    tick();
    check("seq_valid_drop", 32'(o_valid), 32'd0);
    check("seq_ready_back", 32'(o_ready), 32'd1);

    // Backpressure: result must stay put while downstream stalls
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(17'h1FFFE);
    check("bp_valid",   32'(o_valid),   32'd1);
    check("bp_total",   32'(o_total),   32'h7FFF8);
    check("bp_total17", 32'(o_total17), 32'h1FFF8);
    check("bp_ovf17",   32'(o_ovf17),   32'd1);
    i_valid = 1'b1; i_sum = 17'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_total", 32'(o_total), 32'h7FFF8);
      check("bp_hold_ready", 32'(o_ready), 32'd0);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(o_valid), 32'd0);
    check("bp_release_count", 32'(o_count), 32'd0);

    // Overflow on the 17-bit instance, then a clean frame
    send(17'h1FFFE); send(17'h00002); send(17'd0); send(17'd0);
    i_valid = 1'b0;
    check("ovf_total17", 32'(o_total17), 32'h0);
    check("ovf_flag17",  32'(o_ovf17),   32'd1);
    check("ovf_total24", 32'(o_total),   32'h20000);
    check("ovf_flag24",  32'(o_ovf),     32'd0);
    tick();
    for (int i = 0; i < 4; i++) send(17'd1);
    i_valid = 1'b0;
    check("ovf_next_total17", 32'(o_total17), 32'd4);
    check("ovf_next_flag17",  32'(o_ovf17),   32'd0);
    tick();

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      send(17'(5 + i));
      check("gap_count", 32'(o_count), 32'((i + 1) % 4));
      if (i < 3) begin
        i_valid = 1'b0;
        tick();
        check("gap_count_idle", 32'(o_count), 32'(i + 1));
      end
    end
    i_valid = 1'b0;
    check("gap_total", 32'(o_total), 32'd26);
    check("gap_valid", 32'(o_valid), 32'd1);
    tick();

    // Clear mid-frame beats a simultaneous accept
    send(17'd1); send(17'd1);
    check("clr_pre_count", 32'(o_count), 32'd2);
    i_clear = 1'b1; i_valid = 1'b1; i_sum = 17'd7;
    tick();
    i_clear = 1'b0;
    check("clr_count", 32'(o_count), 32'd0);
    check("clr_valid", 32'(o_valid), 32'd0);
    check("clr_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 4; i++) send(17'd1);
    i_valid = 1'b0; i_ready = 1'b0;
    check("clr_total", 32'(o_total), 32'd4);
    tick();
    check("clr_hold_valid", 32'(o_valid), 32'd1);

    // Asynchronous reset in HOLD, away from any clock edge
    #2; i_rst = 1'b1; #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_total", 32'(o_total), 32'd0);
    check("arst_count", 32'(o_count), 32'd0);
    #2; i_rst = 1'b0; i_ready = 1'b1;
    tick();

    // Random stream against a frame-level reference model
    q.delete(); hold = 1'b0; frames = 0;
    exp_total = '0; exp_total17 = '0; exp_ovf = 1'b0; exp_ovf17 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_ready", 32'(o_ready), 32'(!hold));
      check("rnd_valid", 32'(o_valid), 32'(hold));
      if (hold) begin
        check("rnd_total",   32'(o_total),   exp_total);
        check("rnd_ovf",     32'(o_ovf),     32'(exp_ovf));
        check("rnd_total17", 32'(o_total17), exp_total17);
        check("rnd_ovf17",   32'(o_ovf17),   32'(exp_ovf17));
      end else begin
        check("rnd_count", 32'(o_count), 32'(q.size()));
      end

      i_valid = ($urandom_range(0, 3) != 0);
      i_sum   = 17'($urandom);
      i_ready = ($urandom_range(0, 2) == 0);
      i_clear = ($urandom_range(0, 63) == 0);

      if (i_clear) begin
        q.delete();
        hold = 1'b0;
      end else if (hold) begin
        if (i_ready) hold = 1'b0;
      end else if (i_valid) begin
        q.push_back(i_sum);
        if (q.size() == 4) begin
          s = 0;
          foreach (q[k]) s += 64'(q[k]);
          exp_total   = 32'(s % 64'd16777216);
          exp_ovf     = (s >= 64'd16777216);
          exp_total17 = 32'(s % 64'd131072);
          exp_ovf17   = (s >= 64'd131072);
          q.delete();
          hold = 1'b1;
          frames++;
        end
      end
      tick();
    end
    i_clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
